// File: rtl/sr_pulse_driver_if.sv
// Request/status bundle between a requester and sr_pulse_driver, plus the latch feedback q_fb.
// The tgl_req line exists only when SR_TOGGLE_EN is defined.
interface sr_pulse_driver_if;
  logic set_req;
  logic clr_req;
`ifdef SR_TOGGLE_EN
  logic tgl_req;
`endif
  logic q_fb;
  logic s;
  logic r;
  logic busy;
  logic done;
  logic err;

`ifdef SR_TOGGLE_EN
  modport master (
    output set_req, clr_req, tgl_req, q_fb,
    input  s, r, busy, done, err
  );
  modport slave (
    input  set_req, clr_req, tgl_req, q_fb,
    output s, r, busy, done, err
  );
`else
  modport master (
    output set_req, clr_req, q_fb,
    input  s, r, busy, done, err
  );
  modport slave (
    input  set_req, clr_req, q_fb,
    output s, r, busy, done, err
  );
`endif
endinterface

// File: rtl/sr_pulse_driver.sv
// Synchronous front end for a NAND SR latch: one-cycle requests become PW-cycle active-low
// s/r pulses, then q_fb is watched for up to TMO cycles. SR_TOGGLE_EN adds a toggle request.
module sr_pulse_driver #(
  parameter int PW  = 2,
  parameter int TMO = 8,
  parameter int CW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_pulse_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [CW-1:0] PW_LOAD  = CW'(PW - 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(TMO - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exp_q, exp_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          want_set;
  logic          want_clr;
  logic          conflict;

  // Request decode: at most one of want_set/want_clr is ever high, so s and r never both go low.
  always_comb begin
`ifdef SR_TOGGLE_EN
    conflict = (bus.set_req & bus.clr_req)
             | (bus.tgl_req & (bus.set_req | bus.clr_req));
    want_set = ~conflict & (bus.set_req | (bus.tgl_req & ~bus.q_fb));
    want_clr = ~conflict & (bus.clr_req | (bus.tgl_req &  bus.q_fb));
`else
    conflict = bus.set_req & bus.clr_req;
    want_set = bus.set_req & ~bus.clr_req;
    want_clr = bus.clr_req & ~bus.set_req;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      s_q     <= 1'b1;
      r_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state, shared counter and expected latch value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    case (state_q)
      IDLE: begin
        if (want_set) begin
          state_d = PULSE;
          cnt_d   = PW_LOAD;
          exp_d   = 1'b1;
        end else if (want_clr) begin
          state_d = PULSE;
          cnt_d   = PW_LOAD;
          exp_d   = 1'b0;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = TMO_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SETTLE: begin
        if (bus.q_fb == exp_q) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs; the active line simply holds its value through PULSE.
  always_comb begin
    s_d    = s_q;
    r_d    = r_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        s_d    = ~want_set;
        r_d    = ~want_clr;
        busy_d = want_set | want_clr;
        err_d  = conflict;
      end
      PULSE: begin
        if (cnt_q == '0) begin
          s_d = 1'b1;
          r_d = 1'b1;
        end
      end
      SETTLE: begin
        if (bus.q_fb == exp_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (cnt_q == '0) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        s_d    = 1'b1;
        r_d    = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.s    = s_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver (PW=2, TMO=8) with a behavioural NAND latch on q_fb.
// The toggle steps are compiled in only when SR_TOGGLE_EN is defined.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic latch_q   = 1'b0;
  logic stuck_en  = 1'b0;
  logic stuck_val = 1'b0;

  sr_pulse_driver_if bus ();

  sr_pulse_driver #(.PW(2), .TMO(8), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #25 clk = ~clk;

  // Behavioural NAND latch: low s sets, low r clears, otherwise holds.
  always @(bus.s or bus.r) begin
    if (bus.s === 1'b0)      latch_q = 1'b1;
    else if (bus.r === 1'b0) latch_q = 1'b0;
  end

  assign bus.q_fb = stuck_en ? stuck_val : latch_q;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
`ifdef SR_TOGGLE_EN
    bus.tgl_req = 1'b0;
`endif
    #5 rst_n = 1'b0;
    #5;
    chk("rst_s", bus.s, 1'b1);
    chk("rst_r", bus.r, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a set pulse
    bus.set_req = 1'b1;
    step();
    bus.set_req = 1'b0;
    chk("midrst_s_low", bus.s, 1'b0);
    #5 rst_n = 1'b0;
    #1;
    chk("midrst_s", bus.s, 1'b1);
    chk("midrst_r", bus.r, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    #5 rst_n = 1'b1;
    step();
    chk("midrst_idle_s", bus.s, 1'b1);
    chk("midrst_idle_busy", bus.busy, 1'b0);

    // Clear: q_fb held 1 during the pulse, drops to 0 after release
    stuck_en    = 1'b1;
    stuck_val   = 1'b1;
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    chk("clr_r0", bus.r, 1'b0);
    chk("clr_s0", bus.s, 1'b1);
    chk("clr_busy0", bus.busy, 1'b1);
    step();
    chk("clr_r1", bus.r, 1'b0);
    chk("clr_done1", bus.done, 1'b0);
    step();
    chk("clr_rel", bus.r, 1'b1);
    stuck_val = 1'b0;
    step();
    chk("clr_done", bus.done, 1'b1);
    chk("clr_busy_end", bus.busy, 1'b0);
    step();
    chk("clr_done_off", bus.done, 1'b0);
    stuck_en = 1'b0;

    // Set with q_fb following the latch model
    bus.set_req = 1'b1;
    step();
    bus.set_req = 1'b0;
    chk("set_s0", bus.s, 1'b0);
    chk("set_r0", bus.r, 1'b1);
    chk("set_busy0", bus.busy, 1'b1);
    chk("set_done0", bus.done, 1'b0);
    step();
    chk("set_s1", bus.s, 1'b0);
    chk("set_done1", bus.done, 1'b0);
    step();
    chk("set_rel", bus.s, 1'b1);
    chk("set_busy2", bus.busy, 1'b1);
    chk("set_done2", bus.done, 1'b0);
    step();
    chk("set_done", bus.done, 1'b1);
    chk("set_busy3", bus.busy, 1'b0);
    chk("set_err3", bus.err, 1'b0);
    step();
    chk("set_done_off", bus.done, 1'b0);

    // Conflicting request
    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    step();
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    chk("conf_err", bus.err, 1'b1);
    chk("conf_s", bus.s, 1'b1);
    chk("conf_r", bus.r, 1'b1);
    chk("conf_busy", bus.busy, 1'b0);
    step();
    chk("conf_err_off", bus.err, 1'b0);
    chk("conf_s2", bus.s, 1'b1);
    chk("conf_busy2", bus.busy, 1'b0);

    // Timeout: q_fb stuck at 0 after a set
    stuck_en    = 1'b1;
    stuck_val   = 1'b0;
    bus.set_req = 1'b1;
    step();
    bus.set_req = 1'b0;
    step();
    step();
    chk("tmo_rel", bus.s, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("tmo_wait_err", bus.err, 1'b0);
      chk("tmo_wait_busy", bus.busy, 1'b1);
    end
    step();
    chk("tmo_err", bus.err, 1'b1);
    chk("tmo_nodone", bus.done, 1'b0);
    chk("tmo_busy", bus.busy, 1'b0);
    step();
    chk("tmo_err_off", bus.err, 1'b0);
    stuck_en = 1'b0;

    // Requests while busy are dropped (latch model currently 1)
    bus.set_req = 1'b1;
    step();
    bus.set_req = 1'b0;
    bus.clr_req = 1'b1;
    step();
    chk("drop_r", bus.r, 1'b1);
    chk("drop_s", bus.s, 1'b0);
    step();
    chk("drop_rel_r", bus.r, 1'b1);
    step();
    bus.clr_req = 1'b0;
    chk("drop_done", bus.done, 1'b1);
    step();
    chk("drop_done_off", bus.done, 1'b0);
    chk("drop_busy", bus.busy, 1'b0);
    chk("drop_r_idle", bus.r, 1'b1);
    step();
    chk("drop_no_queue", bus.busy, 1'b0);
    chk("drop_single_done", bus.done, 1'b0);

`ifdef SR_TOGGLE_EN
    // Toggle with q_fb=1 issues a clear pulse
    bus.tgl_req = 1'b1;
    step();
    bus.tgl_req = 1'b0;
    chk("tgl_r0", bus.r, 1'b0);
    chk("tgl_s0", bus.s, 1'b1);
    step();
    step();
    chk("tgl_rel", bus.r, 1'b1);
    step();
    chk("tgl_done", bus.done, 1'b1);
    step();
    bus.tgl_req = 1'b1;
    bus.set_req = 1'b1;
    step();
    bus.tgl_req = 1'b0;
    bus.set_req = 1'b0;
    chk("tgl_conf_err", bus.err, 1'b1);
    chk("tgl_conf_s", bus.s, 1'b1);
    chk("tgl_conf_busy", bus.busy, 1'b0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
